// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned GapCntW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StGap
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter handshake bundle for uart_tx_arbiter.
// The arbiter takes the slave view; requesters and the transmitter take the master view.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);

    logic                   baud_tick;
    logic [NUM_REQ-1:0]     req_valid;
    logic [8*NUM_REQ-1:0]   req_data;
    logic [NUM_REQ-1:0]     req_last;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   tx_valid;
    logic [7:0]             tx_data;
    logic                   tx_ready;
    logic [NUM_REQ-1:0]     grant;
    logic                   busy;

    modport master (
        output baud_tick, req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data, grant, busy
    );

    modport slave (
        input  baud_tick, req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data, grant, busy
    );

endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set bit of req searching upward
// from last_owner+1, wrapping at NUM_REQ.
module uart_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    int unsigned      sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = 0;
        idx   = '0;
        // Offset 1..NUM_REQ visits every requester once, last_owner itself last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = 32'(last_owner) + 32'(i);
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IDX_W'(sum);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one UART transmitter, with an
// enforced idle gap of GAP_BITS bit-times between packets.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned GAP_BITS = 2
) (
    input logic              clk,
    input logic              resetn,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e           state;
    logic [NUM_REQ-1:0]   grant;
    logic [IdxW-1:0]      last_owner;
    logic [GapCntW-1:0]   gap_cnt;

    logic [NUM_REQ-1:0]   pick;
    logic                 pick_valid;
    logic [IdxW-1:0]      grant_idx;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 last_xfer;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_picker (
        .req        (bus.req_valid),
        .last_owner (last_owner),
        .pick       (pick),
        .valid      (pick_valid)
    );

    // Grant is only non-zero in XFER, so this mux is naturally idle elsewhere.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_last   = 1'b0;
        req_ready = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IdxW'(i);
                if (state == StXfer) begin
                    tx_valid     = bus.req_valid[i];
                    tx_data      = bus.req_data[8*i +: 8];
                    tx_last      = bus.req_last[i];
                    req_ready[i] = bus.tx_ready;
                end
            end
        end
    end

    assign last_xfer = tx_valid && bus.tx_ready && tx_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= StIdle;
            grant      <= '0;
            last_owner <= IdxW'(NUM_REQ - 1);
            gap_cnt    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pick_valid) begin
                        grant <= pick;
                        state <= StXfer;
                    end
                end
                StXfer: begin
                    // Baud ticks seen here never touch gap_cnt.
                    if (last_xfer) begin
                        last_owner <= grant_idx;
                        grant      <= '0;
                        gap_cnt    <= GapCntW'(GAP_BITS);
                        state      <= (GAP_BITS == 0) ? StIdle : StGap;
                    end
                end
                StGap: begin
                    if (bus.baud_tick) begin
                        gap_cnt <= gap_cnt - 1'b1;
                        if (gap_cnt == GapCntW'(1)) begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.tx_valid  = tx_valid;
    assign bus.tx_data   = tx_data;
    assign bus.req_ready = req_ready;
    assign bus.grant     = grant;
    assign bus.busy      = (state != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one GAP_BITS=2 instance and one GAP_BITS=0 instance.
module tb_uart_tx_arbiter;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    uart_tx_arbiter_if #(.NUM_REQ(4)) b ();
    uart_tx_arbiter_if #(.NUM_REQ(4)) z ();

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_BITS(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (b)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_BITS(0)) dut0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #1 resetn = 1'b0;
        #2 resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        b.baud_tick = 0; b.req_valid = '0; b.req_data = '0; b.req_last = '0; b.tx_ready = 0;
        z.baud_tick = 0; z.req_valid = '0; z.req_data = '0; z.req_last = '0; z.tx_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b want=0000", b.grant); end
        total++; if (b.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", b.busy); end
        total++; if (b.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b want=0", b.tx_valid); end
        total++; if (b.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready got=%b want=0000", b.req_ready); end
        total++; if (b.tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h want=00", b.tx_data); end
        total++; if (z.busy !== 1'b0) begin bad++; $display("FAIL rst_busy0 got=%b want=0", z.busy); end
        #2 resetn = 1'b1;
        tick();
        total++; if (b.busy !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b want=0", b.busy); end
    endtask

    task automatic test_single_packet();
        b.tx_ready = 1; b.req_valid = 4'b0001; b.req_data[7:0] = 8'hA1; b.req_last = 4'b0000;
        #1;
        total++; if (b.tx_valid !== 1'b0) begin bad++; $display("FAIL pkt_idle_txv got=%b want=0", b.tx_valid); end
        tick();
        total++; if (b.grant !== 4'b0001) begin bad++; $display("FAIL pkt_grant got=%b want=0001", b.grant); end
        total++; if (b.tx_data !== 8'hA1) begin bad++; $display("FAIL pkt_b1 got=%h want=a1", b.tx_data); end
        total++; if (b.req_ready !== 4'b0001) begin bad++; $display("FAIL pkt_rdy got=%b want=0001", b.req_ready); end
        tick();
        b.req_data[7:0] = 8'hA2;
        #1;
        total++; if (b.tx_data !== 8'hA2) begin bad++; $display("FAIL pkt_b2 got=%h want=a2", b.tx_data); end
        tick();
        b.req_data[7:0] = 8'hA3; b.req_last = 4'b0001;
        #1;
        total++; if (b.tx_data !== 8'hA3) begin bad++; $display("FAIL pkt_b3 got=%h want=a3", b.tx_data); end
        tick();
        b.req_valid = '0; b.req_last = '0;
        total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL pkt_gap_grant got=%b want=0000", b.grant); end
        total++; if (b.busy !== 1'b1) begin bad++; $display("FAIL pkt_gap_busy got=%b want=1", b.busy); end
        repeat (3) tick();
        total++; if (b.busy !== 1'b1) begin bad++; $display("FAIL pkt_gap_hold got=%b want=1", b.busy); end
        b.baud_tick = 1; tick(); b.baud_tick = 0;
        total++; if (b.busy !== 1'b1) begin bad++; $display("FAIL pkt_gap_one got=%b want=1", b.busy); end
        tick();
        b.baud_tick = 1; tick(); b.baud_tick = 0;
        total++; if (b.busy !== 1'b0) begin bad++; $display("FAIL pkt_gap_end got=%b want=0", b.busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [7:0] exp_d;
        apply_reset();
        b.req_valid = 4'b1111; b.req_last = 4'b1111; b.tx_ready = 1;
        b.req_data = 32'h13121110;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            exp_d = 8'h10 + 8'(k % 4);
            tick();
            total++; if (b.grant !== exp_g) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", k, b.grant, exp_g); end
            total++; if (b.tx_data !== exp_d) begin bad++; $display("FAIL rr_data%0d got=%h want=%h", k, b.tx_data, exp_d); end
            tick();
            total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL rr_gap%0d got=%b want=0000", k, b.grant); end
            b.baud_tick = 1; tick(); tick(); b.baud_tick = 0;
            total++; if (b.busy !== 1'b0) begin bad++; $display("FAIL rr_idle%0d got=%b want=0", k, b.busy); end
        end
        b.req_valid = '0; b.req_last = '0;
    endtask

    task automatic test_lock();
        b.req_valid = 4'b0010; b.req_data[15:8] = 8'h51; b.req_last = 4'b0000;
        tick();
        total++; if (b.grant !== 4'b0010) begin bad++; $display("FAIL lock_grant got=%b want=0010", b.grant); end
        b.req_valid = 4'b0110; b.req_data[23:16] = 8'hEE; b.req_last = 4'b0100;
        tick();
        b.req_data[15:8] = 8'h52;
        #1;
        total++; if (b.grant !== 4'b0010) begin bad++; $display("FAIL lock_hold got=%b want=0010", b.grant); end
        total++; if (b.tx_data !== 8'h52) begin bad++; $display("FAIL lock_data got=%h want=52", b.tx_data); end
        total++; if (b.req_ready !== 4'b0010) begin bad++; $display("FAIL lock_rdy got=%b want=0010", b.req_ready); end
        b.req_valid = 4'b0100;
        #1;
        total++; if (b.tx_valid !== 1'b0) begin bad++; $display("FAIL lock_pause_txv got=%b want=0", b.tx_valid); end
        tick();
        total++; if (b.grant !== 4'b0010) begin bad++; $display("FAIL lock_pause_grant got=%b want=0010", b.grant); end
        b.req_valid = 4'b0110; b.req_data[15:8] = 8'h53; b.req_last = 4'b0110;
        #1;
        total++; if (b.tx_data !== 8'h53) begin bad++; $display("FAIL lock_last got=%h want=53", b.tx_data); end
        tick();
        b.req_valid = 4'b0100;
        b.baud_tick = 1; tick(); b.baud_tick = 0;
        total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL lock_wait got=%b want=0000", b.grant); end
        b.baud_tick = 1; tick(); b.baud_tick = 0;
        total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL lock_idle got=%b want=0000", b.grant); end
        tick();
        total++; if (b.grant !== 4'b0100) begin bad++; $display("FAIL lock_next got=%b want=0100", b.grant); end
        total++; if (b.tx_data !== 8'hEE) begin bad++; $display("FAIL lock_next_data got=%h want=ee", b.tx_data); end
        tick();
        b.req_valid = '0; b.req_last = '0;
        b.baud_tick = 1; tick(); tick(); b.baud_tick = 0;
    endtask

    task automatic test_stall();
        b.req_valid = 4'b1000; b.req_data[31:24] = 8'h77; b.req_last = 4'b1000; b.tx_ready = 0;
        tick();
        for (int i = 0; i < 10; i++) begin
            total++; if (b.tx_valid !== 1'b1) begin bad++; $display("FAIL stall_txv%0d got=%b want=1", i, b.tx_valid); end
            total++; if (b.req_ready !== 4'b0000) begin bad++; $display("FAIL stall_rdy%0d got=%b want=0000", i, b.req_ready); end
            total++; if (b.grant !== 4'b1000) begin bad++; $display("FAIL stall_grant%0d got=%b want=1000", i, b.grant); end
            tick();
        end
        b.tx_ready = 1; b.baud_tick = 1;
        #1;
        total++; if (b.req_ready !== 4'b1000) begin bad++; $display("FAIL stall_release got=%b want=1000", b.req_ready); end
        tick();
        b.baud_tick = 0; b.req_valid = '0; b.req_last = '0;
        total++; if (b.busy !== 1'b1) begin bad++; $display("FAIL coin_gap got=%b want=1", b.busy); end
        b.baud_tick = 1; tick(); b.baud_tick = 0;
        total++; if (b.busy !== 1'b1) begin bad++; $display("FAIL coin_one got=%b want=1", b.busy); end
        b.baud_tick = 1; tick(); b.baud_tick = 0;
        total++; if (b.busy !== 1'b0) begin bad++; $display("FAIL coin_end got=%b want=0", b.busy); end
    endtask

    task automatic test_gap0();
        z.tx_ready = 1; z.req_valid = 4'b0001; z.req_data[7:0] = 8'h3C; z.req_last = 4'b0001;
        tick();
        total++; if (z.grant !== 4'b0001) begin bad++; $display("FAIL g0_grant got=%b want=0001", z.grant); end
        total++; if (z.tx_data !== 8'h3C) begin bad++; $display("FAIL g0_data got=%h want=3c", z.tx_data); end
        tick();
        total++; if (z.busy !== 1'b0) begin bad++; $display("FAIL g0_idle got=%b want=0", z.busy); end
        total++; if (z.grant !== 4'b0000) begin bad++; $display("FAIL g0_clear got=%b want=0000", z.grant); end
        tick();
        total++; if (z.grant !== 4'b0001) begin bad++; $display("FAIL g0_regrant got=%b want=0001", z.grant); end
        tick();
        z.req_valid = '0; z.req_last = '0;
        tick();
        total++; if (z.busy !== 1'b0) begin bad++; $display("FAIL g0_done got=%b want=0", z.busy); end
    endtask

    task automatic test_reset_midpacket();
        b.tx_ready = 1; b.req_valid = 4'b1000; b.req_data[31:24] = 8'h99; b.req_last = 4'b0000;
        tick();
        total++; if (b.grant !== 4'b1000) begin bad++; $display("FAIL mid_grant got=%b want=1000", b.grant); end
        tick();
        total++; if (b.tx_valid !== 1'b1) begin bad++; $display("FAIL mid_txv got=%b want=1", b.tx_valid); end
        resetn = 1'b0;
        #1;
        total++; if (b.grant !== 4'b0000) begin bad++; $display("FAIL mid_rst_grant got=%b want=0000", b.grant); end
        total++; if (b.tx_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_txv got=%b want=0", b.tx_valid); end
        total++; if (b.req_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_rdy got=%b want=0000", b.req_ready); end
        total++; if (b.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", b.busy); end
        b.req_valid = 4'b1001; b.req_data[7:0] = 8'hAB; b.req_last = 4'b0001;
        #1 resetn = 1'b1;
        tick();
        total++; if (b.grant !== 4'b0001) begin bad++; $display("FAIL mid_restart got=%b want=0001", b.grant); end
        total++; if (b.tx_data !== 8'hAB) begin bad++; $display("FAIL mid_restart_data got=%h want=ab", b.tx_data); end
        tick();
        b.req_valid = '0; b.req_last = '0;
        b.baud_tick = 1; tick(); tick(); b.baud_tick = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_lock();
        test_stall();
        test_gap0();
        test_reset_midpacket();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
